// File: rtl/herring_wait_ctrl_if.sv
`default_nettype none
// ============================================================================
// herring_wait_ctrl_if : CPU-side bus bundle for the PHI2 wait-state controller
// Rev 1.0
// ============================================================================
interface herring_wait_ctrl_if;
  logic       phi2;
  logic [5:0] address;
  logic       ext_rdy;
  logic       err_clr;
  logic       rdy;
  logic       wait_busy;
  logic [2:0] region;
  logic       bus_err;

  modport master (
    output phi2, address, ext_rdy, err_clr,
    input  rdy, wait_busy, region, bus_err
  );

  modport slave (
    input  phi2, address, ext_rdy, err_clr,
    output rdy, wait_busy, region, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/herring_wait_ctrl.sv
`default_nettype none
// ============================================================================
// herring_wait_ctrl : stretches 6502 bus cycles via RDY, per address region
// Rev 1.0
// ============================================================================
module herring_wait_ctrl #(
  parameter int unsigned WAIT_ROM  = 2,
  parameter int unsigned WAIT_ACIA = 3,
  parameter int unsigned WAIT_VIA  = 1,
  parameter int unsigned WAIT_IO   = 1,
  parameter int unsigned WAIT_EXP  = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input  wire logic           clk_src,
  input  wire logic           rst,
  herring_wait_ctrl_if.slave  bus
);

  localparam int unsigned c_MAX_A    = (WAIT_ROM > WAIT_ACIA) ? WAIT_ROM : WAIT_ACIA;
  localparam int unsigned c_MAX_B    = (WAIT_VIA > WAIT_IO)   ? WAIT_VIA : WAIT_IO;
  localparam int unsigned c_MAX_C    = (c_MAX_A > c_MAX_B)    ? c_MAX_A  : c_MAX_B;
  localparam int unsigned c_MAX_WAIT = (c_MAX_C > WAIT_EXP)   ? c_MAX_C  : WAIT_EXP;
  localparam int unsigned c_CNT_W    = (c_MAX_WAIT < 2) ? 1 : $clog2(c_MAX_WAIT + 1);
  localparam int unsigned c_TO_W     = (TIMEOUT < 2)    ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_COUNT  = 2'd1;
  localparam logic [1:0] c_EXTEND = 2'd2;

  localparam logic [2:0] c_RGN_RAM  = 3'd0;
  localparam logic [2:0] c_RGN_ACIA = 3'd1;
  localparam logic [2:0] c_RGN_VIA  = 3'd2;
  localparam logic [2:0] c_RGN_IO   = 3'd3;
  localparam logic [2:0] c_RGN_EXP  = 3'd4;
  localparam logic [2:0] c_RGN_ROM  = 3'd5;

  logic [1:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q,   cnt_d;
  logic [c_TO_W-1:0]  tcnt_q,  tcnt_d;
  logic [2:0]         region_q, region_d;
  logic               bus_err_q, bus_err_d;
  logic               phi2_q;

  logic               w_phi2_rise;
  logic [2:0]         w_rgn;
  logic [c_CNT_W-1:0] w_wait;
  logic [c_TO_W-1:0]  w_tcnt_inc;
  logic               w_err_set;

  assign w_phi2_rise = bus.phi2 & ~phi2_q;
  assign w_tcnt_inc  = tcnt_q + c_TO_W'(1);

  // address is A[15:10]; anything below 0x8000 is RAM
  always_comb begin
    w_rgn = c_RGN_RAM;
    if (bus.address[5]) begin
      if (bus.address[4:3] == 2'b11)        w_rgn = c_RGN_ROM;
      else if (bus.address[4:0] == 5'b00000) w_rgn = c_RGN_ACIA;
      else if (bus.address[4:0] == 5'b00001) w_rgn = c_RGN_VIA;
      else if (bus.address[4:1] == 4'b0001)  w_rgn = c_RGN_IO;
      else                                   w_rgn = c_RGN_EXP;
    end
  end

  always_comb begin
    w_wait = '0;
    case (w_rgn)
      c_RGN_ACIA: w_wait = c_CNT_W'(WAIT_ACIA);
      c_RGN_VIA:  w_wait = c_CNT_W'(WAIT_VIA);
      c_RGN_IO:   w_wait = c_CNT_W'(WAIT_IO);
      c_RGN_EXP:  w_wait = c_CNT_W'(WAIT_EXP);
      c_RGN_ROM:  w_wait = c_CNT_W'(WAIT_ROM);
      default:    w_wait = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    region_d  = region_q;
    w_err_set = 1'b0;
    if (w_phi2_rise) begin
      case (state_q)
        c_IDLE: begin
          region_d = w_rgn;
          if (w_wait != '0) begin
            cnt_d   = w_wait;
            state_d = c_COUNT;
          end
        end
        c_COUNT: begin
          cnt_d = cnt_q - c_CNT_W'(1);
          if (cnt_q == c_CNT_W'(1)) begin
            if ((region_q == c_RGN_EXP) && !bus.ext_rdy) begin
              tcnt_d  = '0;
              state_d = c_EXTEND;
            end else begin
              state_d = c_IDLE;
            end
          end
        end
        c_EXTEND: begin
          if (bus.ext_rdy) begin
            state_d = c_IDLE;
          end else begin
            tcnt_d = w_tcnt_inc;
            if (w_tcnt_inc >= c_TO_W'(TIMEOUT)) begin
              w_err_set = 1'b1;
              state_d   = c_IDLE;
            end
          end
        end
        default: state_d = c_IDLE;
      endcase
    end
  end

  // a timeout in the same cycle as err_clr wins
  assign bus_err_d = w_err_set | (bus_err_q & ~bus.err_clr);

  always_ff @(posedge clk_src or posedge rst) begin
    if (rst) begin
      state_q   <= c_IDLE;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      region_q  <= c_RGN_RAM;
      bus_err_q <= 1'b0;
      phi2_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      region_q  <= region_d;
      bus_err_q <= bus_err_d;
      phi2_q    <= bus.phi2;
    end
  end

  assign bus.wait_busy = (state_q != c_IDLE);
  assign bus.rdy       = (state_q == c_IDLE);
  assign bus.region    = region_q;
  assign bus.bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_herring_wait_ctrl.sv
`default_nettype none
// ============================================================================
// tb_herring_wait_ctrl : randomized scoreboard bench for herring_wait_ctrl
// Rev 1.0
// ============================================================================
module tb_herring_wait_ctrl;

  localparam int W_ROM  = 2;
  localparam int W_ACIA = 3;
  localparam int W_VIA  = 1;
  localparam int W_IO   = 1;
  localparam int W_EXP  = 2;
  localparam int TMO    = 64;

  typedef struct packed {
    logic       rdy;
    logic [2:0] region;
    logic       bus_err;
  } exp_t;

  logic clk_src = 1'b0;
  logic rst     = 1'b1;
  always #10 clk_src = ~clk_src;

  herring_wait_ctrl_if bus ();

  herring_wait_ctrl #(
    .WAIT_ROM (W_ROM),
    .WAIT_ACIA(W_ACIA),
    .WAIT_VIA (W_VIA),
    .WAIT_IO  (W_IO),
    .WAIT_EXP (W_EXP),
    .TIMEOUT  (TMO)
  ) dut (
    .clk_src(clk_src),
    .rst    (rst),
    .bus    (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_edges  = 0;
  logic m_err    = 1'b0;

  function automatic logic [2:0] ref_region(input logic [15:0] a);
    if (a < 16'h8000)       return 3'd0;
    else if (a <= 16'h83FF) return 3'd1;
    else if (a <= 16'h87FF) return 3'd2;
    else if (a <= 16'h8FFF) return 3'd3;
    else if (a <= 16'hDFFF) return 3'd4;
    else                    return 3'd5;
  endfunction

  function automatic int ref_wait(input logic [2:0] r);
    case (r)
      3'd1:    return W_ACIA;
      3'd2:    return W_VIA;
      3'd3:    return W_IO;
      3'd4:    return W_EXP;
      3'd5:    return W_ROM;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one PHI2 period: low phase carries address noise, then the rising edge
  task automatic phi_edge(input logic [15:0] a, input logic ext, input logic clr, input exp_t e);
    @(negedge clk_src);
    bus.phi2    = 1'b0;
    bus.address = 6'($urandom);
    @(negedge clk_src);
    bus.address = a[15:10];
    sb.push_back(e);
    @(negedge clk_src);
    bus.phi2    = 1'b1;
    bus.ext_rdy = ext;
    bus.err_clr = clr;
    @(negedge clk_src);
    bus.err_clr = 1'b0;
    bus.address = 6'($urandom);
  endtask

  // k: extra EXTEND edges before ext_rdy rises (k > TMO means never)
  task automatic access(input logic [15:0] a, input int k, input logic clr_at_to);
    logic [2:0] r;
    int         n;
    int         rel;
    logic       to;
    logic       ext;
    logic       c;
    exp_t       e;
    r = ref_region(a);
    n = ref_wait(r);
    c = ($urandom_range(0, 7) == 0);
    if (c) m_err = 1'b0;
    e = '{rdy: (n == 0), region: r, bus_err: m_err};
    phi_edge(a, 1'($urandom), c, e);
    if (n == 0) return;
    if (r == 3'd4 && k > TMO) begin
      rel = n + TMO;
      to  = 1'b1;
    end else begin
      rel = (r == 3'd4) ? n + k : n;
      to  = 1'b0;
    end
    for (int j = 1; j <= rel; j++) begin
      if (r == 3'd4 && j >= n) ext = (j == n + k);
      else                     ext = 1'($urandom);
      if (j == rel && to) begin
        c     = clr_at_to;
        m_err = 1'b1;
      end else begin
        c = ($urandom_range(0, 15) == 0);
        if (c) m_err = 1'b0;
      end
      e = '{rdy: (j == rel), region: r, bus_err: m_err};
      phi_edge(16'($urandom), ext, c, e);
    end
  endtask

  task automatic clear_pulse();
    @(negedge clk_src);
    bus.err_clr = 1'b1;
    @(negedge clk_src);
    bus.err_clr = 1'b0;
    m_err = 1'b0;
    #1;
    check("err_clr_pulse", {31'd0, bus.bus_err}, 32'd0);
  endtask

  // monitor: every PHI2 rising edge the DUT sees produces one scoreboard entry
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk_src);
      if (!rst && bus.phi2 && !prev) begin
        #1;
        n_edges++;
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL edge_unexpected: got edge %0d expected none", n_edges);
        end else begin
          e = sb.pop_front();
          check($sformatf("edge%0d rdy/busy/region/err", n_edges),
                {26'd0, bus.rdy, bus.wait_busy, bus.region, bus.bus_err},
                {26'd0, e.rdy, ~e.rdy, e.region, e.bus_err});
        end
      end
      prev = rst ? 1'b0 : bus.phi2;
    end
  end

  initial begin
    exp_t e;
    int   k;
    bus.phi2    = 1'b0;
    bus.address = '0;
    bus.ext_rdy = 1'b0;
    bus.err_clr = 1'b0;
    #5;
    check("reset_state", {26'd0, bus.rdy, bus.wait_busy, bus.region, bus.bus_err},
          {26'd0, 1'b1, 1'b0, 3'd0, 1'b0});
    repeat (3) @(negedge clk_src);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) access(16'h0000, 0, 1'b0);
    access(16'h8000, 0, 1'b0);
    access(16'h9000, 4, 1'b0);
    access(16'h9000, TMO, 1'b0);
    access(16'hA000, TMO + 1, 1'b0);
    clear_pulse();
    access(16'hA000, TMO + 5, 1'b1);
    access(16'h8400, 0, 1'b0);
    access(16'h0000, 0, 1'b0);
    access(16'h8C00, 0, 1'b0);

    // asynchronous reset in the middle of a ROM stretch, with bus_err still set
    e = '{rdy: 1'b0, region: 3'd5, bus_err: m_err};
    phi_edge(16'hE000, 1'b0, 1'b0, e);
    phi_edge(16'h0000, 1'b0, 1'b0, e);
    @(negedge clk_src);
    bus.phi2 = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async_reset", {26'd0, bus.rdy, bus.wait_busy, bus.region, bus.bus_err},
          {26'd0, 1'b1, 1'b0, 3'd0, 1'b0});
    m_err = 1'b0;
    @(negedge clk_src);
    @(negedge clk_src);
    rst = 1'b0;
    access(16'h8000, 0, 1'b0);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) k = TMO - 1 + $urandom_range(0, 2);
      else                           k = $urandom_range(0, 4);
      access(16'($urandom), k, 1'($urandom));
      if ($urandom_range(0, 19) == 0) clear_pulse();
    end

    repeat (4) @(negedge clk_src);
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/herring_wait_ctrl.md
HERRING_WAIT_CTRL -- requirements
Module: herring_wait_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  WAIT_ROM     2    PHI2 wait cycles for 0xE000-0xFFFF
  WAIT_ACIA    3    PHI2 wait cycles for 0x8000-0x83FF
  WAIT_VIA     1    PHI2 wait cycles for 0x8400-0x87FF
  WAIT_IO      1    PHI2 wait cycles for 0x8800-0x8FFF
  WAIT_EXP     2    minimum PHI2 wait cycles for 0x9000-0xDFFF
  TIMEOUT      64   PHI2 cycles allowed in EXTEND before forced release
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk_src    in   1  50 MHz clock; sole clock
  rst        in   1  reset, asynchronous, active-high
  phi2       in   1  CPU clock level, synchronous to clk_src
  address    in   6  CPU address[15:10]
  ext_rdy    in   1  expansion ready, high = device done
  err_clr    in   1  clears bus_err, one-cycle pulse
  rdy        out  1  CPU RDY, low = stretch current cycle
  wait_busy  out  1  high while a stretch is in progress
  region     out  3  region latched at last evaluated edge
  bus_err    out  1  sticky timeout flag
REQ-003 Reset SHALL be asynchronous and active-high on rst; clock SHALL be clk_src only.

Function
REQ-004 SHALL detect a PHI2 rising edge as phi2 high in the current clk_src cycle while the registered phi2 was low; all state changes other than err_clr and reset SHALL occur only on clk_src edges where such an edge is detected.
REQ-005 Region encoding SHALL be: 0 RAM (0x0000-0x7FFF, also unmapped), 1 ACIA, 2 VIA, 3 IO, 4 EXP, 5 ROM; 6-7 unused.
REQ-006 RAM region SHALL have zero wait cycles.
REQ-007 States SHALL be IDLE, COUNT, EXTEND.
REQ-008 IDLE, PHI2 edge: latch region from address; if its wait count N>0, drive rdy low, load counter with N, go to COUNT; if N=0, stay IDLE with rdy high.
REQ-009 COUNT, PHI2 edge: decrement counter; when the counter decrements from 1 to 0: if region is EXP and ext_rdy low, go EXTEND with rdy low; else rdy high, go IDLE.
REQ-010 RDY SHALL therefore be low for exactly N PHI2 rising edges after the triggering edge, for all N>0.
REQ-011 EXTEND, PHI2 edge: if ext_rdy high, rdy high, go IDLE; else increment timeout counter; when the counter reaches TIMEOUT, set bus_err, rdy high, go IDLE.
REQ-012 The PHI2 edge that releases rdy SHALL NOT re-evaluate address; the next PHI2 edge in IDLE SHALL.
REQ-013 A wait count parameter of 0 for any region SHALL behave as RAM.
REQ-014 wait_busy SHALL equal (state != IDLE); rdy SHALL equal ~wait_busy.
REQ-015 bus_err SHALL stay set until err_clr; if err_clr and a new timeout occur in the same cycle, bus_err SHALL be set.
REQ-016 Counter widths SHALL hold the largest wait parameter and TIMEOUT without wrap; the timeout counter SHALL clear on entry to EXTEND.
REQ-017 Address changes between PHI2 edges SHALL be ignored.

Reset
REQ-018 While rst is high: state IDLE, rdy 1, wait_busy 0, region 0, bus_err 0, counters 0, registered phi2 0.
REQ-019 Reset asserted mid-stretch SHALL release rdy immediately (asynchronously), with no bus_err.
REQ-020 After rst deasserts, the first PHI2 rising edge SHALL be evaluated normally.

Verification
REQ-021 Address 0x0000, run 10 PHI2 cycles -> rdy constantly 1, region 0.
REQ-022 Address 0x8000 at edge E -> rdy low from E through E+2, high after E+3, region 1.
REQ-023 Address 0x9000, ext_rdy 0 until 5 PHI2 edges after E, then 1 -> rdy low from E until that sixth edge, bus_err 0.
REQ-024 Address 0xA000, ext_rdy held 0 -> rdy released after 2+64 PHI2 edges, bus_err 1; err_clr pulse -> bus_err 0.
REQ-025 Address 0xE000, rst pulsed one PHI2 edge after E -> rdy 1 at once, state IDLE, region 0, bus_err 0.
REQ-026 Back-to-back accesses 0x8400 then 0x0000 -> one-edge stretch, release, next edge no stretch, region 0.
